// File: rtl/vga_scan_driver.sv
// VGA scan driver: divided pixel tick, h/v scan counters, and a one-tick registered
// output stage that keeps sync, blanking and colour aligned with the sampled display bit.
module vga_scan_driver #(
    parameter int          CLK_DIV  = 4,
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        display,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // 11-bit bounds so a 1024-wide timing cannot wrap a sync edge to zero.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_video_on;
    logic             r_hsync;
    logic             r_vsync;
    logic [11:0]      r_rgb;

    logic             w_tick;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_active;
    logic             w_hsync_n;
    logic             w_vsync_n;
    logic [10:0]      w_h_ext;
    logic [10:0]      w_v_ext;
    logic [11:0]      w_color;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_h_last  = (r_h == H_LAST);
    assign w_v_last  = (r_v == V_LAST);
    assign w_h_ext   = {1'b0, r_h};
    assign w_v_ext   = {1'b0, r_v};

    assign w_active  = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
    assign w_hsync_n = !((w_h_ext >= HS_START) && (w_h_ext < HS_END));
    assign w_vsync_n = !((w_v_ext >= VS_START) && (w_v_ext < VS_END));

    // Outer select on w_active keeps an undriven display bit out of the blanking interval.
    assign w_color   = w_active ? (display ? FG_COLOR : BG_COLOR) : 12'h000;

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_video_on <= 1'b0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_rgb      <= 12'h000;
        end else if (w_tick) begin
            r_video_on <= w_active;
            r_hsync    <= w_hsync_n;
            r_vsync    <= w_vsync_n;
            r_rgb      <= w_color;
        end
    end

    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign video_on    = r_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;
    assign frame_start = w_tick && w_h_last && w_v_last;

endmodule
